// File: rtl/vga_timing_ctrl.sv
// Sequencing controller for a horizontal/vertical vga_sync_gen pair: pixel-rate
// enable divider, frame-aligned start/stop and registered, polarity-adjusted VGA outputs.
module vga_timing_ctrl #(
  parameter int unsigned PIX_DIV     = 1,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic                   h_en,
  output logic                   v_en,
  input  logic                   h_sync_i,
  input  logic                   h_active_i,
  input  logic                   h_cycle_i,
  input  logic                   v_sync_i,
  input  logic                   v_active_i,
  input  logic                   v_cycle_i,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0]       DIV_ONE  = DIV_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FC_ONE   = FRAME_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   h_active_q, h_active_d;
  logic                   v_active_q, v_active_d;
  logic                   busy_q, busy_d;
  logic                   vga_hs_q, vga_hs_d;
  logic                   vga_vs_q, vga_vs_d;
  logic                   vga_de_q, vga_de_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic tick_s;
  logic frame_edge_s;
  logic frame_end_s;
  logic running_s;
  logic unused_s;

  assign tick_s       = (state_q != ST_IDLE) && (div_q == DIV_LAST);
  assign frame_edge_s = tick_s && v_active_i && !v_active_q;
  assign frame_end_s  = tick_s && !v_active_i && v_active_q;
  assign running_s    = (state_q == ST_RUN);
  // v_cycle_i is reserved on the interface and intentionally not consumed.
  assign unused_s     = v_cycle_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stop seen while running is remembered until the active area ends.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        stop_pend_d = 1'b0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (frame_edge_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (frame_end_s && stop_pend_q) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          state_d     = ST_RUN;
          stop_pend_d = stop_pend_q || stop;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    h_en = tick_s;
    v_en = tick_s && h_cycle_i;

    if (state_q == ST_IDLE) begin
      div_d = {DIV_W{1'b0}};
    end else if (div_q == DIV_LAST) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_ONE;
    end

    if (tick_s) begin
      h_active_d = h_active_i;
      v_active_d = v_active_i;
    end else begin
      h_active_d = h_active_q;
      v_active_d = v_active_q;
    end

    line_start_d  = tick_s && running_s && h_active_i && !h_active_q && v_active_i;
    // A stop arriving on the aligning tick wins, so no frame is announced.
    frame_start_d = frame_edge_s && (running_s || ((state_q == ST_SYNC) && !stop));

    if (frame_start_d) begin
      frame_count_d = frame_count_q + FC_ONE;
    end else begin
      frame_count_d = frame_count_q;
    end

    if (running_s && h_sync_i) begin
      vga_hs_d = HSYNC_POL;
    end else begin
      vga_hs_d = ~HSYNC_POL;
    end

    if (running_s && v_sync_i) begin
      vga_vs_d = VSYNC_POL;
    end else begin
      vga_vs_d = ~VSYNC_POL;
    end

    vga_de_d = running_s && h_active_i && v_active_i;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= {DIV_W{1'b0}};
      stop_pend_q   <= 1'b0;
      h_active_q    <= 1'b0;
      v_active_q    <= 1'b0;
      busy_q        <= 1'b0;
      vga_hs_q      <= ~HSYNC_POL;
      vga_vs_q      <= ~VSYNC_POL;
      vga_de_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= {FRAME_CNT_W{1'b0}};
    end else begin
      div_q         <= div_d;
      stop_pend_q   <= stop_pend_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      busy_q        <= busy_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_de_q      <= vga_de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy        = busy_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_de      = vga_de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: behavioural 10x5 sync generators, a frame_count
// scoreboard queue checked by a monitor, and directed start/stop/reset sequences.
module tb_vga_timing_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PIX_DIV=2, active-low syncs
  logic        start_a = 1'b0, stop_a = 1'b0;
  logic        busy_a, h_en_a, v_en_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [15:0] fc_a;
  logic [3:0]  hp_a = 4'd0;
  logic [2:0]  vp_a = 3'd0;
  logic        h_sync_a, h_active_a, h_cycle_a, v_sync_a, v_active_a, v_cycle_a;

  // Instance B: PIX_DIV=1, active-high hsync
  logic        start_b = 1'b0, stop_b = 1'b0;
  logic        busy_b, h_en_b, v_en_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [15:0] fc_b;
  logic [3:0]  hp_b = 4'd0;
  logic [2:0]  vp_b = 3'd0;
  logic        h_sync_b, h_active_b, h_cycle_b, v_sync_b, v_active_b, v_cycle_b;

  // Generators: horizontal fp2/sync2/bp2/active4, vertical fp1/sync1/bp1/active2
  always @(posedge clk) begin
    if (h_en_a) hp_a <= (hp_a == 4'd9) ? 4'd0 : hp_a + 4'd1;
    if (v_en_a) vp_a <= (vp_a == 3'd4) ? 3'd0 : vp_a + 3'd1;
    if (h_en_b) hp_b <= (hp_b == 4'd9) ? 4'd0 : hp_b + 4'd1;
    if (v_en_b) vp_b <= (vp_b == 3'd4) ? 3'd0 : vp_b + 3'd1;
  end
  assign h_sync_a   = (hp_a == 4'd2) || (hp_a == 4'd3);
  assign h_active_a = (hp_a >= 4'd6);
  assign h_cycle_a  = (hp_a == 4'd9);
  assign v_sync_a   = (vp_a == 3'd1);
  assign v_active_a = (vp_a >= 3'd3);
  assign v_cycle_a  = (vp_a == 3'd4);
  assign h_sync_b   = (hp_b == 4'd2) || (hp_b == 4'd3);
  assign h_active_b = (hp_b >= 4'd6);
  assign h_cycle_b  = (hp_b == 4'd9);
  assign v_sync_b   = (vp_b == 3'd1);
  assign v_active_b = (vp_b >= 3'd3);
  assign v_cycle_b  = (vp_b == 3'd4);

  vga_timing_ctrl #(.PIX_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .busy(busy_a),
    .h_en(h_en_a), .v_en(v_en_a),
    .h_sync_i(h_sync_a), .h_active_i(h_active_a), .h_cycle_i(h_cycle_a),
    .v_sync_i(v_sync_a), .v_active_i(v_active_a), .v_cycle_i(v_cycle_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_ctrl #(.PIX_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .FRAME_CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .busy(busy_b),
    .h_en(h_en_b), .v_en(v_en_b),
    .h_sync_i(h_sync_b), .h_active_i(h_active_b), .h_cycle_i(h_cycle_b),
    .v_sync_i(v_sync_b), .v_active_i(v_active_b), .v_cycle_i(v_cycle_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  int checks = 0;
  int errors = 0;
  int exp_fc_q[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor state for instance A
  int cyc = 0, last_fs = 0, lines_since = 0, de_runs_since = 0, de_run = 0, h_since_v = 0;
  bit fs_valid = 1'b0, v_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n || !busy_a) begin
      fs_valid = 1'b0;
      v_valid  = 1'b0;
      de_run   = 0;
    end
    if (rst_n) begin
      if (fs_a) begin
        if (exp_fc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_start: frame_count=%0d, no frame expected", fc_a);
        end else begin
          check("frame_count", int'(fc_a), exp_fc_q.pop_front());
        end
        if (fs_valid) begin
          check("frame_period", cyc - last_fs, 100);
          check("line_starts_per_frame", lines_since, 2);
          check("de_lines_per_frame", de_runs_since, 2);
        end
        fs_valid      = 1'b1;
        last_fs       = cyc;
        lines_since   = 0;
        de_runs_since = 0;
      end
      if (ls_a) lines_since++;
      if (de_a) begin
        de_run++;
      end else if (de_run > 0) begin
        check("de_run_len", de_run, 8);
        de_runs_since++;
        de_run = 0;
      end
      if (h_en_a) h_since_v++;
      if (v_en_a) begin
        if (v_valid) check("h_en_per_v_en", h_since_v, 10);
        v_valid   = 1'b1;
        h_since_v = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, de_early, bad, bad_w, hs_run, hs_runs;
    logic prev_h, prev_va;

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_h_en", h_en_a, 0);
    check("rst_v_en", v_en_a, 0);
    check("rst_hs", hs_a, 1);
    check("rst_vs", vs_a, 1);
    check("rst_de", de_a, 0);
    check("rst_fc", int'(fc_a), 0);
    check("rst_hs_b", hs_b, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (h_en_a || busy_a) cnt++;
    end
    check("idle_h_en_busy", cnt, 0);
    check("idle_hs", hs_a, 1);
    check("idle_vs", vs_a, 1);
    check("idle_de", de_a, 0);
    check("idle_fc", int'(fc_a), 0);

    // Start pulse and alignment to the first frame
    start_a = 1'b1;
    exp_fc_q.push_back(1);
    @(negedge clk);
    start_a = 1'b0;
    check("start_busy", busy_a, 1);
    check("start_h_en_wait", h_en_a, 0);
    @(negedge clk);
    check("start_first_h_en", h_en_a, 1);
    @(negedge clk);
    check("start_h_en_alt", h_en_a, 0);
    n = 0;
    de_early = 0;
    while (!fs_a && n < 300) begin
      if (de_a) de_early++;
      @(negedge clk);
      n++;
    end
    check("first_frame_start_seen", fs_a, 1);
    check("de_before_first_frame", de_early, 0);
    @(negedge clk);
    check("fc_after_first_frame", int'(fc_a), 1);

    // Steady running for three more frames
    exp_fc_q.push_back(2);
    exp_fc_q.push_back(3);
    exp_fc_q.push_back(4);
    n = 0;
    while (exp_fc_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("steady_frames_done", exp_fc_q.size(), 0);

    // Stop in the middle of the first visible line
    repeat (14) @(negedge clk);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("stop_still_busy", busy_a, 1);
    n = 0;
    prev_h = h_en_a;
    prev_va = v_active_a;
    while (busy_a && n < 300) begin
      prev_h  = h_en_a;
      prev_va = v_active_a;
      @(negedge clk);
      n++;
    end
    check("stop_busy_fall", busy_a, 0);
    check("stop_waits_frame_end", int'(n > 10), 1);
    check("stop_last_h_en", prev_h, 1);
    check("stop_v_active_low", prev_va, 0);
    check("stop_h_en_off", h_en_a, 0);
    check("stop_hs", hs_a, 1);
    check("stop_vs", vs_a, 1);
    check("stop_de", de_a, 0);
    check("stop_fc", int'(fc_a), 4);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (h_en_a) cnt++;
    end
    check("stopped_h_en_quiet", cnt, 0);

    // Restart: resync and the counter continues
    start_a = 1'b1;
    exp_fc_q.push_back(5);
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (exp_fc_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("restart_frame_done", exp_fc_q.size(), 0);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    n = 0;
    while (busy_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("second_stop_idle", busy_a, 0);

    // start and stop together in IDLE
    start_a = 1'b1;
    stop_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    cnt = 0;
    repeat (5) begin
      if (busy_a) cnt++;
      @(negedge clk);
    end
    check("start_stop_stays_idle", cnt, 0);

    // stop while SYNCING
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("sync_busy", busy_a, 1);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("sync_stop_idle", busy_a, 0);
    cnt = 0;
    repeat (20) begin
      if (fs_a || busy_a) cnt++;
      @(negedge clk);
    end
    check("sync_stop_no_frame", cnt, 0);
    check("sync_stop_fc", int'(fc_a), 5);

    // Asynchronous reset in the middle of a visible line
    start_a = 1'b1;
    exp_fc_q.push_back(6);
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (exp_fc_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_frame_done", exp_fc_q.size(), 0);
    n = 0;
    while (!de_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_de_high", de_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_h_en", h_en_a, 0);
    check("arst_v_en", v_en_a, 0);
    check("arst_hs", hs_a, 1);
    check("arst_vs", vs_a, 1);
    check("arst_de", de_a, 0);
    check("arst_line_start", ls_a, 0);
    check("arst_frame_start", fs_a, 0);
    check("arst_fc", int'(fc_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: active-high hsync and an enable on every clk
    @(negedge clk);
    check("b_hs_idle", hs_b, 0);
    check("b_vs_idle", vs_b, 1);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    bad = 0;
    bad_w = 0;
    hs_run = 0;
    hs_runs = 0;
    check("b_hs_after_start", hs_b, 0);
    repeat (200) begin
      if (!busy_b || !h_en_b) bad++;
      if (hs_b) begin
        hs_run++;
      end else if (hs_run > 0) begin
        hs_runs++;
        if (hs_run != 2) bad_w++;
        hs_run = 0;
      end
      @(negedge clk);
    end
    check("b_h_en_constant", bad, 0);
    check("b_hs_width", bad_w, 0);
    check("b_hs_pulses", hs_runs, 17);

    check("sb_queue_empty", exp_fc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
